lfsr_arbiter: RTL and testbench

Round-robin controller that shares one Galois LFSR random-number generator among N_REQ requesters. Each grant advances the LFSR a fixed number of steps and hands the resulting word to exactly one requester with a one-cycle grant/valid pulse. Reseeding is handled safely at any time: a seed that arrives mid-delivery is held until the delivery ends. The block sits between the pseudo-random datapath (the LFSR) and the consumers that draw words from it.

---
 rtl/lfsr_arb_pkg.sv | 42 ++++
 rtl/lfsr_arbiter_if.sv | 30 +++
 rtl/lfsr_arbiter_galois_lfsr.sv | 31 +++
 rtl/lfsr_arbiter.sv | 137 +++++++++++++
 tb/tb_lfsr_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_arb_pkg.sv
// lfsr_arb_pkg: shared types, defaults and the round-robin pick function
// for lfsr_arbiter.
//   state_t    : controller FSM states (IDLE, STEP, DONE)
//   DEF_TAPS   : default Galois feedback mask (x^8+x^6+x^5+x^4+1)
//   DEF_SEED   : default reset / zero-substitution seed
//   rr_pick()  : first set request at or after ptr, wrapping mod n_req
package lfsr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    DONE
  } state_t;

  localparam logic [7:0]  DEF_TAPS = 8'hB8;
  localparam logic [7:0]  DEF_SEED = 8'h01;
  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned PTR_W    = 3;

  // Scans ptr, ptr+1, ... mod n_req and returns the first set request.
  // Only called when at least one request is set.
  function automatic logic [PTR_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [PTR_W-1:0]   ptr,
    input int unsigned        n_req
  );
    logic [PTR_W-1:0] win;
    logic             found;
    int unsigned      idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = (32'(ptr) + i) % n_req;
      if (i < n_req && !found && req[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = idx[PTR_W-1:0];
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/lfsr_arbiter_if.sv
// lfsr_arbiter_if: request/grant/seed bundle between lfsr_arbiter and its
// consumers.
//   req       : per-requester level request
//   seed_ld   : one-cycle seed load pulse, seed_in carries the value
//   gnt       : one-hot grant pulse, rnd_valid = |gnt
//   rnd_data  : current LFSR state
//   busy      : arbiter is in STEP or DONE
// Modports: master = requester side, slave = arbiter side.
interface lfsr_arbiter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic             seed_ld;
  logic [WIDTH-1:0] seed_in;
  logic [N_REQ-1:0] gnt;
  logic             rnd_valid;
  logic [WIDTH-1:0] rnd_data;
  logic             busy;

  modport master (
    output req, seed_ld, seed_in,
    input  gnt, rnd_valid, rnd_data, busy
  );

  modport slave (
    input  req, seed_ld, seed_in,
    output gnt, rnd_valid, rnd_data, busy
  );
endinterface

// File: rtl/lfsr_arbiter_galois_lfsr.sv
// galois_lfsr: right-shifting Galois LFSR with parallel load.
//   clk, rst : clock, synchronous active-high reset (q <= SEED)
//   en       : advance one step
//   ld, d    : load d (ld has priority over en); no zero check here
//   q        : current state
module galois_lfsr
  import lfsr_arb_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS,
  parameter logic [WIDTH-1:0] SEED  = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else if (ld) begin
      q <= d;
    end else if (en) begin
      q <= q[0] ? ((q >> 1) ^ TAPS) : (q >> 1);
    end
  end

endmodule

// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter: round-robin sharing of one Galois LFSR among N_REQ
// requesters. Each grant advances the LFSR STEPS times, then pulses
// gnt[winner] and rnd_valid for one cycle. Seeds arriving while busy are
// held and applied in the next IDLE cycle ahead of arbitration.
//   clk, rst : clock, synchronous active-high reset
//   bus      : lfsr_arbiter_if.slave (req, seed_ld, seed_in, gnt,
//              rnd_valid, rnd_data, busy)
//   gnt_cnt  : saturating grant counter, present only when
//              LFSR_ARB_STATS_EN is defined
module lfsr_arbiter
  import lfsr_arb_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter int unsigned      N_REQ = 4,
  parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS,
  parameter logic [WIDTH-1:0] SEED  = DEF_SEED,
  parameter int unsigned      STEPS = 1
) (
  input  logic                clk,
  input  logic                rst,
  lfsr_arbiter_if.slave       bus
`ifdef LFSR_ARB_STATS_EN
  ,
  output logic [15:0]         gnt_cnt
`endif
);

  localparam int unsigned CW = $clog2(STEPS + 1);

  state_t             state, state_nx;
  logic [PTR_W-1:0]   ptr, winner;
  logic [CW-1:0]      step_cnt;
  logic               pend_vld;
  logic [WIDTH-1:0]   pend_val;
  logic [MAX_REQ-1:0] req_ext;
  logic               take, lfsr_en, lfsr_ld;
  logic [WIDTH-1:0]   seed_src, lfsr_d, lfsr_q;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = bus.req;
  end

  // A fresh pulse in IDLE supersedes any held seed.
  assign seed_src = bus.seed_ld ? bus.seed_in : pend_val;
  assign lfsr_d   = (seed_src == '0) ? SEED : seed_src;

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    lfsr_en  = 1'b0;
    lfsr_ld  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.seed_ld || pend_vld) begin
          lfsr_ld = 1'b1;
        end else if (|bus.req) begin
          take     = 1'b1;
          state_nx = STEP;
        end
      end
      STEP: begin
        lfsr_en = 1'b1;
        if (step_cnt == CW'(STEPS - 1)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      winner   <= '0;
      step_cnt <= '0;
      pend_vld <= 1'b0;
      pend_val <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        winner   <= rr_pick(req_ext, ptr, N_REQ);
        step_cnt <= '0;
      end else if (state == STEP) begin
        step_cnt <= step_cnt + 1'b1;
      end
      if (state == DONE) begin
        ptr <= (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
      end
      if (state != IDLE && bus.seed_ld) begin
        pend_vld <= 1'b1;
        pend_val <= bus.seed_in;
      end else if (lfsr_ld) begin
        pend_vld <= 1'b0;
      end
    end
  end

  galois_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (lfsr_en),
    .ld  (lfsr_ld),
    .d   (lfsr_d),
    .q   (lfsr_q)
  );

  assign bus.gnt       = (state == DONE) ? (N_REQ'(1) << winner) : '0;
  assign bus.rnd_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.rnd_data  = lfsr_q;

`ifdef LFSR_ARB_STATS_EN
  logic [15:0] stat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt <= '0;
    end else if (state == DONE && stat_cnt != '1) begin
      stat_cnt <= stat_cnt + 16'd1;
    end
  end

  assign gnt_cnt = stat_cnt;
`endif

endmodule

// File: tb/tb_lfsr_arbiter.sv
// tb_lfsr_arbiter: self-checking bench for lfsr_arbiter.
// dut1 (STEPS=1) is checked every cycle against a transaction-level model;
// dut4 (STEPS=4) covers a seed arriving mid-delivery.
// Define LFSR_ARB_STATS_EN to also check gnt_cnt.
module tb_lfsr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_arbiter_if #(.WIDTH(8), .N_REQ(4)) if1 ();
  lfsr_arbiter_if #(.WIDTH(8), .N_REQ(4)) if4 ();

`ifdef LFSR_ARB_STATS_EN
  logic [15:0] cnt1, cnt4;
`endif

  lfsr_arbiter #(.WIDTH(8), .N_REQ(4), .TAPS(8'hB8), .SEED(8'h01), .STEPS(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
`ifdef LFSR_ARB_STATS_EN
    , .gnt_cnt (cnt1)
`endif
  );

  lfsr_arbiter #(.WIDTH(8), .N_REQ(4), .TAPS(8'hB8), .SEED(8'h01), .STEPS(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
`ifdef LFSR_ARB_STATS_EN
    , .gnt_cnt (cnt4)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model for dut1: phase counts busy cycles left (0 = idle,
  // 1 = grant cycle); the word is computed in one go at acceptance.
  logic [7:0] m_lfsr, m_pend_val;
  bit         m_pend;
  int         m_ptr, m_win, m_phase;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_adv(input logic [7:0] x, input int n);
    logic [7:0] v;
    v = x;
    for (int i = 0; i < n; i++) v = (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
    return v;
  endfunction

  task automatic model_reset();
    m_lfsr = 8'h01; m_pend = 0; m_pend_val = 8'h00;
    m_ptr = 0; m_win = 0; m_phase = 0;
  endtask

  task automatic model_edge();
    if (m_phase == 0) begin
      if (if1.seed_ld || m_pend) begin
        m_lfsr = if1.seed_ld ? if1.seed_in : m_pend_val;
        if (m_lfsr == 8'h00) m_lfsr = 8'h01;
        m_pend = 0;
      end else if (if1.req != 4'b0000) begin
        for (int i = 3; i >= 0; i--) if (if1.req[(m_ptr + i) % 4]) m_win = (m_ptr + i) % 4;
        m_lfsr  = lfsr_adv(m_lfsr, 1);
        m_phase = 2;
      end
    end else begin
      if (if1.seed_ld) begin
        m_pend = 1;
        m_pend_val = if1.seed_in;
      end
      if (m_phase == 1) m_ptr = (m_win + 1) % 4;
      m_phase--;
    end
  endtask

  task automatic tick();
    logic [3:0] exp_g;
    if (rst) model_reset(); else model_edge();
    @(posedge clk);
    #1;
    exp_g = (m_phase == 1) ? 4'(1 << m_win) : 4'b0000;
    check("m_gnt",   32'(if1.gnt),       32'(exp_g));
    check("m_valid", 32'(if1.rnd_valid), 32'(m_phase == 1));
    check("m_busy",  32'(if1.busy),      32'(m_phase != 0));
    if (m_phase <= 1) check("m_data", 32'(if1.rnd_data), 32'(m_lfsr));
  endtask

  logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    int ngr, last;
    if1.req = '0; if1.seed_ld = 1'b0; if1.seed_in = '0;
    if4.req = '0; if4.seed_ld = 1'b0; if4.seed_in = '0;

    // Reset state
    rst = 1'b1; tick(); tick();
    check("rst_gnt",   32'(if1.gnt), 0);
    check("rst_valid", 32'(if1.rnd_valid), 0);
    check("rst_busy",  32'(if1.busy), 0);
    check("rst_data",  32'(if1.rnd_data), 'h01);
    check("rst_data4", 32'(if4.rnd_data), 'h01);
    rst = 1'b0;

    // First word and its successor
    if1.req = 4'b0001; tick();
    check("busy_step", 32'(if1.busy), 1);
    tick();
    check("gnt_first",  32'(if1.gnt), 'b0001);
    check("data_first", 32'(if1.rnd_data), 'hB8);
    if1.req = 4'b0000; tick();
    if1.req = 4'b0001; tick(); tick();
    check("gnt_second",  32'(if1.gnt), 'b0001);
    check("data_second", 32'(if1.rnd_data), 'h5C);
    if1.req = 4'b0000; tick();

    // Round-robin with all requests held, from ptr=0
    rst = 1'b1; tick(); rst = 1'b0;
    if1.req = 4'b1111; ngr = 0; last = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (if1.gnt != 4'b0000) begin
        if (ngr < 5) check("rr_order", 32'(if1.gnt), 32'(order[ngr]));
        if (ngr > 0) check("rr_spacing", 32'(c - last), 3);
        last = c;
        ngr++;
      end
    end
    check("rr_count", 32'(ngr), 5);
    if1.req = 4'b0000; tick();

`ifdef LFSR_ARB_STATS_EN
    check("gnt_cnt5", 32'(cnt1), 5);
    force dut1.stat_cnt = 16'hFFFF;
    tick();
    release dut1.stat_cnt;
    if1.req = 4'b0001; tick(); tick();
    if1.req = 4'b0000; tick();
    check("gnt_cnt_sat", 32'(cnt1), 'hFFFF);
`endif

    // Zero seed is replaced by SEED
    if1.seed_ld = 1'b1; if1.seed_in = 8'h00; tick();
    if1.seed_ld = 1'b0;
    check("zero_seed", 32'(if1.rnd_data), 'h01);
    if1.req = 4'b0100; tick(); tick();
    check("gnt_after_seed",  32'(if1.gnt), 'b0100);
    check("data_after_seed", 32'(if1.rnd_data), 'hB8);
    if1.req = 4'b0000; tick();

    // STEPS=4: seed arriving during STEP is held until the next IDLE
    if4.req = 4'b0001; tick();
    check("busy4", 32'(if4.busy), 1);
    if4.seed_ld = 1'b1; if4.seed_in = 8'h80; tick();
    if4.seed_ld = 1'b0;
    tick(); tick(); tick();
    check("gnt4_old",   32'(if4.gnt), 'b0001);
    check("valid4_old", 32'(if4.rnd_valid), 1);
    check("data4_old",  32'(if4.rnd_data), 'h17);
    if4.req = 4'b0000; tick();
    check("idle4_busy", 32'(if4.busy), 0);
    check("idle4_data", 32'(if4.rnd_data), 'h17);
    tick();
    check("seed4_load", 32'(if4.rnd_data), 'h80);
    if4.req = 4'b0010; tick(); tick(); tick(); tick(); tick();
    check("gnt4_new",  32'(if4.gnt), 'b0010);
    check("data4_new", 32'(if4.rnd_data), 'h08);
    if4.req = 4'b0000; tick();
`ifdef LFSR_ARB_STATS_EN
    check("gnt_cnt4", 32'(cnt4), 2);
`endif

    // Reset during STEP aborts the grant
    if1.req = 4'b0010; tick();
    check("abort_busy", 32'(if1.busy), 1);
    rst = 1'b1; if1.req = 4'b0000; tick();
    check("abort_gnt",  32'(if1.gnt), 0);
    check("abort_busy0", 32'(if1.busy), 0);
    check("abort_data", 32'(if1.rnd_data), 'h01);
    rst = 1'b0; tick();
    check("abort_nogrant", 32'(if1.gnt), 0);
    if1.req = 4'b1111; tick(); tick();
    check("abort_ptr0", 32'(if1.gnt), 'b0001);
    if1.req = 4'b0000; tick();

    // Randomized traffic and seeds against the model
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (if1.gnt[i]) if1.req[i] = 1'b0;
        else if (!if1.req[i] && $urandom_range(0, 3) == 0) if1.req[i] = 1'b1;
      end
      if1.seed_ld = ($urandom_range(0, 11) == 0);
      if1.seed_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      tick();
    end
    if1.req = 4'b0000; if1.seed_ld = 1'b0;
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
